// File: rtl/time_entry_decoder_pkg.sv
// Shared constants, state encoding and nibble layout for keypad time entry.
package time_entry_decoder_pkg;

  localparam int DIGITS_PER_TIME = 6;
  localparam int NIBBLE_W        = 4;

  // Nibble positions within the 32-bit entry echo (nibble 0 = bits [3:0]).
  localparam int NIB_H10 = 7;
  localparam int NIB_H1  = 6;
  localparam int NIB_M10 = 5;
  localparam int NIB_M1  = 4;
  localparam int NIB_S10 = 3;
  localparam int NIB_S1  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    REPORT  = 2'd3
  } state_t;

  // Bit offset of the nibble that receives the next digit, given how many
  // digits have already been captured (0..5).
  function automatic logic [4:0] nib_lsb(input logic [2:0] captured);
    logic [2:0] nib;
    nib = 3'(NIB_H10) - captured;
    return {nib, 2'b00};
  endfunction

endpackage

// File: rtl/time_entry_decoder_bcd2_to_bin.sv
// Two-digit BCD to binary: tens*8 + tens*2 + ones, no multiplier.
module bcd2_to_bin (
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] bin
);

  // Shift-add conversion; inputs are already limited to 0..9 so 7 bits suffice.
  assign bin = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};

endmodule

// File: rtl/time_entry_decoder.sv
// Collects six BCD digits (HH MM SS), range-checks them and publishes
// binary hour/min/second with a valid or error pulse.
//
// state   | meaning
// IDLE    | waiting for the first digit (H10)
// COLLECT | capturing H1..S1 into the echo register
// CHECK   | one cycle: convert and range-check, latch result if legal
// REPORT  | one cycle: emit time_valid or time_err, clear the entry
module time_entry_decoder
  import time_entry_decoder_pkg::*;
#(
  parameter int MAX_HOUR   = 23,
  parameter int MAX_MINSEC = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit,
  input  logic        digit_valid,
  output logic        digit_ready,
  input  logic        clear,
  output logic [5:0]  hour,
  output logic [5:0]  min,
  output logic [5:0]  second,
  output logic        time_valid,
  output logic        time_err,
  output logic [2:0]  digit_cnt,
  output logic [31:0] entry_disp
);

  localparam logic [6:0] MAX_H      = 7'(MAX_HOUR);
  localparam logic [6:0] MAX_MS     = 7'(MAX_MINSEC);
  localparam bit         TWELVE_HR  = (MAX_HOUR == 12);
  localparam logic [2:0] LAST_IDX   = 3'(DIGITS_PER_TIME - 1);

  state_t     state, state_nxt;
  logic       take;
  logic       digit_bad;
  logic [4:0] cap_lsb;
  logic [6:0] h_bin, m_bin, s_bin;
  logic       in_range;
  logic       pass_q;

  assign take      = digit_valid && digit_ready && !clear;
  assign digit_bad = (digit > 4'd9);
  assign cap_lsb   = nib_lsb(digit_cnt);

  bcd2_to_bin u_hour_conv (
    .tens (entry_disp[NIB_H10*NIBBLE_W +: NIBBLE_W]),
    .ones (entry_disp[NIB_H1*NIBBLE_W  +: NIBBLE_W]),
    .bin  (h_bin)
  );

  bcd2_to_bin u_min_conv (
    .tens (entry_disp[NIB_M10*NIBBLE_W +: NIBBLE_W]),
    .ones (entry_disp[NIB_M1*NIBBLE_W  +: NIBBLE_W]),
    .bin  (m_bin)
  );

  bcd2_to_bin u_sec_conv (
    .tens (entry_disp[NIB_S10*NIBBLE_W +: NIBBLE_W]),
    .ones (entry_disp[NIB_S1*NIBBLE_W  +: NIBBLE_W]),
    .bin  (s_bin)
  );

  // A 12-hour build has no hour zero.
  assign in_range = (h_bin <= MAX_H) && (m_bin <= MAX_MS) && (s_bin <= MAX_MS) &&
                    (!TWELVE_HR || (h_bin != 7'd0));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake readiness.
  always_comb begin
    state_nxt   = state;
    digit_ready = (state == IDLE) || (state == COLLECT);
    case (state)
      IDLE: begin
        if (take && !digit_bad) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (take) begin
          if (digit_bad)                  state_nxt = IDLE;
          else if (digit_cnt == LAST_IDX) state_nxt = CHECK;
        end
      end
      CHECK:   state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Digit capture, result latching and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_cnt  <= '0;
      entry_disp <= '0;
      hour       <= '0;
      min        <= '0;
      second     <= '0;
      time_valid <= 1'b0;
      time_err   <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      time_valid <= 1'b0;
      time_err   <= 1'b0;
      if (clear) begin
        digit_cnt  <= '0;
        entry_disp <= '0;
      end else begin
        case (state)
          IDLE, COLLECT: begin
            if (take) begin
              if (digit_bad) begin
                time_err   <= 1'b1;
                digit_cnt  <= '0;
                entry_disp <= '0;
              end else begin
                entry_disp[cap_lsb +: NIBBLE_W] <= digit;
                digit_cnt                       <= digit_cnt + 3'd1;
              end
            end
          end
          CHECK: begin
            pass_q <= in_range;
            if (in_range) begin
              hour   <= h_bin[5:0];
              min    <= m_bin[5:0];
              second <= s_bin[5:0];
            end
          end
          REPORT: begin
            time_valid <= pass_q;
            time_err   <= !pass_q;
            digit_cnt  <= '0;
            entry_disp <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_time_entry_decoder.sv
// Self-checking bench: directed entries plus random keypad traffic, compared
// every cycle against a digit-queue reference model.
module tb_time_entry_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  digit = '0;
  logic        digit_valid = 1'b0;
  logic        digit_ready;
  logic        clear = 1'b0;
  logic [5:0]  hour, min, second;
  logic        time_valid, time_err;
  logic [2:0]  digit_cnt;
  logic [31:0] entry_disp;

  int checks = 0;
  int errors = 0;

  time_entry_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .clear       (clear),
    .hour        (hour),
    .min         (min),
    .second      (second),
    .time_valid  (time_valid),
    .time_err    (time_err),
    .digit_cnt   (digit_cnt),
    .entry_disp  (entry_disp)
  );

  always #5 clk = ~clk;

  // Reference model: digits typed so far, cycles left before the result is
  // reported (2 = conversion pending, 1 = report pending), and latched time.
  int q[$];
  int busy   = 0;
  bit res_ok = 0;
  int m_hour = 0, m_min = 0, m_sec = 0;
  bit m_valid = 0, m_err = 0;

  function automatic logic [31:0] model_disp();
    logic [31:0] d;
    d = '0;
    foreach (q[i]) d = d | (32'(q[i]) << (28 - 4 * i));
    return d;
  endfunction

  task automatic model_reset();
    q.delete();
    busy = 0; res_ok = 0;
    m_hour = 0; m_min = 0; m_sec = 0;
    m_valid = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    int h, mi, s;
    m_valid = 0;
    m_err   = 0;
    if (c) begin
      q.delete();
      busy = 0;
    end else if (busy == 2) begin
      h  = q[0] * 10 + q[1];
      mi = q[2] * 10 + q[3];
      s  = q[4] * 10 + q[5];
      res_ok = (h <= 23) && (mi <= 59) && (s <= 59);
      if (res_ok) begin
        m_hour = h; m_min = mi; m_sec = s;
      end
      busy = 1;
    end else if (busy == 1) begin
      m_valid = res_ok;
      m_err   = !res_ok;
      q.delete();
      busy = 0;
    end else if (v) begin
      if (d > 9) begin
        m_err = 1;
        q.delete();
      end else begin
        q.push_back(d);
        if (q.size() == 6) busy = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("hour",        32'(hour),        32'(m_hour));
    chk("min",         32'(min),         32'(m_min));
    chk("second",      32'(second),      32'(m_sec));
    chk("time_valid",  32'(time_valid),  32'(m_valid));
    chk("time_err",    32'(time_err),    32'(m_err));
    chk("digit_cnt",   32'(digit_cnt),   32'(q.size()));
    chk("entry_disp",  entry_disp,       model_disp());
    chk("digit_ready", 32'(digit_ready), 32'(busy == 0));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check at
  // the next falling edge.
  task automatic cycle(input bit v, input int d, input bit c);
    digit_valid = v;
    digit       = 4'(d);
    clear       = c;
    @(posedge clk);
    model_step(v, d, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input int d);
    cycle(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0);
  endtask

  initial begin
    int seq_a[6] = '{1, 2, 3, 4, 5, 6};
    int seq_b[6] = '{2, 4, 0, 0, 0, 0};
    int seq_c[6] = '{0, 9, 6, 0, 0, 0};
    int seq_d[6] = '{2, 3, 5, 9, 5, 9};
    int seq_e[6] = '{0, 0, 0, 0, 0, 1};

    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    foreach (seq_a[i]) send(seq_a[i]);
    idle(3);
    chk("plan_a_hour", 32'(hour), 32'd12);
    foreach (seq_b[i]) send(seq_b[i]);
    idle(3);
    chk("plan_b_hold", {26'd0, min}, 32'd34);
    foreach (seq_c[i]) send(seq_c[i]);
    idle(3);
    foreach (seq_d[i]) send(seq_d[i]);
    idle(3);
    chk("plan_d_sec", 32'(second), 32'd59);

    send(1);
    send(10);
    idle(2);

    send(1); send(2); send(3);
    chk("plan_disp_before", entry_disp, 32'h1230_0000);
    cycle(1'b1, 4, 1'b1);
    chk("plan_disp_after", entry_disp, 32'h0);
    idle(3);

    // Clear landing on the conversion cycle discards the result.
    foreach (seq_e[i]) send(seq_e[i]);
    cycle(1'b0, 0, 1'b1);
    idle(3);

    // Asynchronous reset mid-entry.
    send(1); send(2); send(3); send(4);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    foreach (seq_e[i]) send(seq_e[i]);
    idle(3);
    chk("plan_rst_sec", 32'(second), 32'd1);

    // Random keypad traffic.
    for (int n = 0; n < 3000; n++) begin
      bit v, c;
      int d;
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 11))
        0:       d = $urandom_range(10, 15);
        1, 2:    d = $urandom_range(0, 2);
        3, 4, 5: d = $urandom_range(0, 5);
        default: d = $urandom_range(0, 9);
      endcase
      cycle(v, d, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_entry_decoder.md
Name: time_entry_decoder

Overview:
Accepts a time typed as six BCD digits (H10 H1 M10 M1 S10 S1), one digit per handshake, e.g. from the keypad scanner. It validates the digits against clock ranges and converts them to binary hour/min/second, ready to load into the time counter. It is the entry-side inverse of the binary-to-BCD display path. It also gives a live packed-nibble echo of the digits typed so far, for the 7-segment display.

Parameters:
MAX_HOUR, 23, largest legal hour value (use 12 for a 12-hour build; a 12-hour build also rejects hour 0).
MAX_MINSEC, 59, largest legal minute/second value.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
digit  input  4  BCD digit being offered
digit_valid  input  1  digit is offered this cycle
digit_ready  output  1  block can accept a digit this cycle
clear  input  1  abort the entry in progress and return to IDLE
hour  output  6  binary hour of the last accepted time
min  output  6  binary minute of the last accepted time
second  output  6  binary second of the last accepted time
time_valid  output  1  one-cycle pulse: hour/min/second just updated
time_err  output  1  one-cycle pulse: entry rejected
digit_cnt  output  3  number of digits captured so far (0..6)
entry_disp  output  32  echo of captured digits: [31:28]=H10, [27:24]=H1, [23:20]=M10, [19:16]=M1, [15:12]=S10, [11:8]=S1, [7:0]=0; uncaptured nibbles=0

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; digit_cnt=0; entry_disp=0.
  - hour/min/second=0; time_valid=0; time_err=0.
- Handshake:
  - A digit transfers on a rising edge when digit_valid && digit_ready.
  - digit_ready=1 in IDLE and COLLECT; 0 in CHECK and REPORT.
- States:
  - IDLE:
    - Transfer of digit ≤ 9 → capture into nibble H10, digit_cnt=1, go to COLLECT.
    - Transfer of digit > 9 → time_err pulse next cycle; stay in IDLE; nothing captured.
  - COLLECT:
    - Each transfer captures into the next nibble in the order H10, H1, M10, M1, S10, S1, and increments digit_cnt.
    - A digit > 9 → time_err pulse next cycle; digits, digit_cnt and entry_disp cleared; go to IDLE.
    - The 6th capture moves to CHECK.
  - CHECK (1 cycle):
    - Compute h=H10*10+H1, m=M10*10+M1, s=S10*10+S1 (7-bit intermediates; shift-add, no multiplier).
    - If h ≤ MAX_HOUR and m ≤ MAX_MINSEC and s ≤ MAX_MINSEC, register h/m/s. When MAX_HOUR=12, h must also be ≥ 1.
    - Go to REPORT.
  - REPORT (1 cycle):
    - Pulse time_valid on a pass or time_err on a fail, never both.
    - Clear digit_cnt and entry_disp; go to IDLE.
- Latency: 6th digit accepted at edge N → outputs updated at edge N+1, pulse visible during the cycle after edge N+2.
- hour/min/second hold their last good value through failed entries and through new entries in progress.
- clear:
  - Synchronous. In any state it forces IDLE, digit_cnt=0, entry_disp=0.
  - No pulse is produced; hour/min/second are unchanged.
  - clear with digit_valid in the same cycle: clear wins and the digit is discarded.
  - clear during CHECK: the result is discarded.
- digit_valid while digit_ready=0 is ignored; the source must hold the digit.
- entry_disp updates on the edge that captures each digit.

Decomposition:
- Shared time package holds:
  - constants DIGITS_PER_TIME=6 and NIBBLE_W=4;
  - the state encoding (IDLE, COLLECT, CHECK, REPORT);
  - the nibble-index constants for the entry_disp layout.
- One natural sub-module, bcd2_to_bin: combinational, two BCD nibbles in, 7-bit binary out (tens*8 + tens*2 + ones). Instantiate it three times.

Test Plan:
- Digits 1,2,3,4,5,6 sent back-to-back → hour=12, min=34, second=56; time_valid pulses exactly once, 2 cycles after the last accept; digit_cnt returns to 0.
- Digits 2,4,0,0,0,0 → time_err pulse; hour/min/second keep their previous values (12/34/56).
- Digits 0,9,6,0,0,0 → time_err because minute=60; then 2,3,5,9,5,9 → hour=23, min=59, second=59, time_valid.
- Digits 1,0xA → time_err the cycle after the 0xA accept; digit_cnt=0; entry_disp=0.
- Digits 1,2,3 then clear together with digit_valid (digit=4) → IDLE, digit_cnt=0, no pulse; entry_disp reads 0x12300000 before the clear and 0 after.
- Assert rst asynchronously mid-entry (after 4 digits) → all outputs 0 immediately; a subsequent full entry of 0,0,0,0,0,1 gives second=1 with time_valid.
